gip_sram_byte_write_controller: RTL and testbench

Request-side front end for the 2048 x 32 single-port synchronous SRAM. The SRAM has no byte enables, so this block accepts word-addressed read and write requests with per-byte enables from the GIP memory client. It issues full-word writes directly and turns partial writes into a two-cycle read-modify-write sequence. It also returns read data on a registered response port. It sits directly upstream of the SRAM macro and drives all of that macro's inputs.

---
 rtl/gip_sram_byte_write_controller.sv | 135 +++++++++++++
 tb/tb_gip_sram_byte_write_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gip_sram_byte_write_controller.sv
// Request front end for the 2048x32 SRAM macro: full-word writes pass
// straight through, partial writes become a read-modify-write pair.
module gip_sram_byte_write_controller (
  input  logic        int_clock,
  input  logic        int_reset,
  input  logic        req_valid,
  output logic        req_ack,
  input  logic        req_read,
  input  logic [10:0] req_address,
  input  logic [3:0]  req_byte_enables,
  input  logic [31:0] req_write_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        sram_read,
  output logic        sram_write,
  output logic [10:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [31:0] sram_read_data
);

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        rd_pend_q, rd_pend_d;
  logic [10:0] mrg_addr_q, mrg_addr_d;
  logic [3:0]  mrg_be_q, mrg_be_d;
  logic [31:0] mrg_data_q, mrg_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        is_full;
  logic        is_zero;
  logic        in_idle;
  logic        acc_rd;
  logic        acc_part;
  logic [31:0] merged;

  assign is_full  = (req_byte_enables == 4'hF);
  assign is_zero  = (req_byte_enables == 4'h0);
  assign in_idle  = int_reset && (state_q == IDLE);
  assign acc_rd   = in_idle && req_valid && req_read;
  assign acc_part = in_idle && req_valid && !req_read
                    && !is_full && !is_zero;

  always_ff @(posedge int_clock or negedge int_reset) begin
    if (!int_reset) begin
      state_q     <= IDLE;
      rd_pend_q   <= 1'b0;
      mrg_addr_q  <= '0;
      mrg_be_q    <= '0;
      mrg_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      mrg_addr_q  <= mrg_addr_d;
      mrg_be_q    <= mrg_be_d;
      mrg_data_q  <= mrg_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (acc_part) state_d = MERGE;
      MERGE: state_d = IDLE;
    endcase
  end

  always_comb begin
    mrg_addr_d  = mrg_addr_q;
    mrg_be_d    = mrg_be_q;
    mrg_data_d  = mrg_data_q;
    rd_pend_d   = acc_rd;
    rsp_valid_d = rd_pend_q;
    rsp_data_d  = rsp_data_q;
    if (acc_part) begin
      mrg_addr_d = req_address;
      mrg_be_d   = req_byte_enables;
      mrg_data_d = req_write_data;
    end
    if (rd_pend_q) rsp_data_d = sram_read_data;
  end

  // Latched bytes win where enabled, the SRAM word fills the rest.
  always_comb begin
    merged = sram_read_data;
    for (int i = 0; i < 4; i++) begin
      if (mrg_be_q[i]) merged[8*i +: 8] = mrg_data_q[8*i +: 8];
    end
  end

  always_comb begin
    req_ack         = 1'b0;
    sram_read       = 1'b0;
    sram_write      = 1'b0;
    sram_address    = '0;
    sram_write_data = '0;
    if (int_reset) begin
      unique case (state_q)
        IDLE: begin
          req_ack = req_valid;
          if (req_valid) begin
            if (req_read) begin
              sram_read    = 1'b1;
              sram_address = req_address;
            end else if (is_full) begin
              sram_write      = 1'b1;
              sram_address    = req_address;
              sram_write_data = req_write_data;
            end else if (!is_zero) begin
              sram_read    = 1'b1;
              sram_address = req_address;
            end
          end
        end
        MERGE: begin
          sram_write      = 1'b1;
          sram_address    = mrg_addr_q;
          sram_write_data = merged;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_gip_sram_byte_write_controller.sv
// Bench for gip_sram_byte_write_controller with a behavioural SRAM
// and a response scoreboard keyed on data and arrival cycle.
module tb_gip_sram_byte_write_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ack;
  logic        req_read = 1'b0;
  logic [10:0] req_address = '0;
  logic [3:0]  req_byte_enables = '0;
  logic [31:0] req_write_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        sram_read;
  logic        sram_write;
  logic [10:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data = '0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] mem [2048];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          st;

  gip_sram_byte_write_controller dut (
    .int_clock        (clk),
    .int_reset        (rst_n),
    .req_valid        (req_valid),
    .req_ack          (req_ack),
    .req_read         (req_read),
    .req_address      (req_address),
    .req_byte_enables (req_byte_enables),
    .req_write_data   (req_write_data),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .sram_read        (sram_read),
    .sram_write       (sram_write),
    .sram_address     (sram_address),
    .sram_write_data  (sram_write_data),
    .sram_read_data   (sram_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (sram_write) mem[sram_address] <= sram_write_data;
    if (sram_read) sram_read_data <= mem[sram_address];
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected got=%h", rsp_data);
      end else begin
        e = sb.pop_front();
        if (rsp_data !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL rsp got=%h@%0d exp=%h@%0d",
                   rsp_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic [10:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    req_valid        = 1'b1;
    req_read         = rd;
    req_address      = a;
    req_byte_enables = be;
    req_write_data   = d;
    #1;
  endtask

  task automatic accept(input logic [31:0] exp, output int stalls);
    stalls = 0;
    while (!req_ack && stalls < 4) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    n_chk++;
    if (!req_ack) begin
      n_fail++;
      $display("FAIL accept_timeout got=0 exp=1");
    end else if (req_read) begin
      sb.push_back('{exp, cyc + 2});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_read  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_timeout pending=%0d exp=0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    req_valid        = 1'b1;
    req_read         = 1'b1;
    req_address      = 11'h003;
    req_byte_enables = 4'h0;
    repeat (3) begin
      @(negedge clk);
      #1;
      n_chk++;
      if ({rsp_valid, req_ack, sram_read, sram_write} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_ctl got=%b exp=0000",
                 {rsp_valid, req_ack, sram_read, sram_write});
      end
      n_chk++;
      if (rsp_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rsp_data got=%h exp=0", rsp_data);
      end
      n_chk++;
      if (sram_address !== 11'h0 || sram_write_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_bus got=%h/%h exp=0/0",
                 sram_address, sram_write_data);
      end
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (req_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_ack got=%b exp=1", req_ack);
    end
    accept(32'h0, st);
    idle();
    wait_rsp();
  endtask

  task automatic test_full_write();
    issue(1'b0, 11'h005, 4'hF, 32'hDEADBEEF);
    n_chk++;
    if (sram_write !== 1'b1 || req_ack !== 1'b1 || sram_read !== 1'b0
        || sram_address !== 11'h005
        || sram_write_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL full_write got=%b%b%b %h %h exp=110 005 deadbeef",
               sram_write, req_ack, sram_read,
               sram_address, sram_write_data);
    end
    accept(32'h0, st);
    n_chk++;
    if (st != 0) begin
      n_fail++;
      $display("FAIL full_write_stall got=%0d exp=0", st);
    end
    issue(1'b1, 11'h005, 4'b0101, 32'h0);
    accept(32'hDEADBEEF, st);
    idle();
    wait_rsp();
  endtask

  task automatic test_partial();
    issue(1'b0, 11'h7FF, 4'hF, 32'h11223344);
    accept(32'h0, st);
    issue(1'b0, 11'h7FF, 4'b0101, 32'hAABBCCDD);
    n_chk++;
    if (sram_read !== 1'b1 || sram_write !== 1'b0 || req_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_first got=%b%b%b exp=101",
               sram_read, sram_write, req_ack);
    end
    accept(32'h0, st);
    issue(1'b1, 11'h7FF, 4'h0, 32'h0);
    n_chk++;
    if (req_ack !== 1'b0 || sram_write !== 1'b1 || sram_read !== 1'b0
        || sram_address !== 11'h7FF
        || sram_write_data !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL partial_merge got=%b%b%b %h %h exp=010 7ff 11bb33dd",
               req_ack, sram_write, sram_read,
               sram_address, sram_write_data);
    end
    accept(32'h11BB33DD, st);
    n_chk++;
    if (st != 1) begin
      n_fail++;
      $display("FAIL partial_stall got=%0d exp=1", st);
    end
    idle();
    wait_rsp();
  endtask

  task automatic test_zero_enable();
    issue(1'b0, 11'h000, 4'hF, 32'hCAFEF00D);
    accept(32'h0, st);
    issue(1'b0, 11'h000, 4'h0, 32'hFFFFFFFF);
    n_chk++;
    if (req_ack !== 1'b1 || sram_read !== 1'b0 || sram_write !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_en got=%b%b%b exp=100",
               req_ack, sram_read, sram_write);
    end
    accept(32'h0, st);
    issue(1'b1, 11'h000, 4'h0, 32'h0);
    accept(32'hCAFEF00D, st);
    idle();
    wait_rsp();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 11'h010, 4'hF, 32'h0BADF00D);
    accept(32'h0, st);
    issue(1'b0, 11'h011, 4'hF, 32'h12345678);
    accept(32'h0, st);
    issue(1'b1, 11'h010, 4'h0, 32'h0);
    accept(32'h0BADF00D, st);
    issue(1'b0, 11'h011, 4'b1000, 32'h99000000);
    accept(32'h0, st);
    n_chk++;
    if (st != 0) begin
      n_fail++;
      $display("FAIL b2b_part_stall got=%0d exp=0", st);
    end
    issue(1'b1, 11'h011, 4'h0, 32'h0);
    accept(32'h99345678, st);
    n_chk++;
    if (st != 1) begin
      n_fail++;
      $display("FAIL b2b_read_stall got=%0d exp=1", st);
    end
    issue(1'b1, 11'h010, 4'h0, 32'h0);
    accept(32'h0BADF00D, st);
    issue(1'b1, 11'h011, 4'h0, 32'h0);
    accept(32'h99345678, st);
    idle();
    wait_rsp();
  endtask

  task automatic test_reset_merge();
    issue(1'b0, 11'h020, 4'hF, 32'h0);
    accept(32'h0, st);
    issue(1'b0, 11'h020, 4'b0001, 32'hFFFFFFFF);
    accept(32'h0, st);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    n_chk++;
    if (sram_write !== 1'b0 || req_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_merge got=%b%b exp=00", sram_write, req_ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 11'h020, 4'h0, 32'h0);
    accept(32'h0, st);
    idle();
    wait_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_write();
    test_partial();
    test_zero_enable();
    test_back_to_back();
    test_reset_merge();
    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL final_pending got=%0d exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
